// File: rtl/mem_lsu.sv
`timescale 1ns/1ps
// mem_lsu: load/store unit between the MEM stage and a byte-wide data memory.
// One request at a time is split into 1, 2 or 4 little-endian byte
// transactions on a req/ready/rvalid port; loads are reassembled and extended.
// Optional feature macro: MEM_LSU_ALIGN_CHECK_EN rejects misaligned half/word
// requests with a one-cycle Err pulse alongside Done.
module mem_lsu #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Req,
  input  logic          MemWr,
  input  logic [1:0]    Size,
  input  logic          Signed,
  input  logic [AW-1:0] Addr,
  input  logic [31:0]   Di,
  output logic [31:0]   Do,
  output logic          Busy,
  output logic          Done,
  output logic          Err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [7:0]    m_wdata,
  input  logic          m_ready,
  input  logic          m_rvalid,
  input  logic [7:0]    m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, DONE} state_t;

  state_t          state, state_nxt;
  logic            wr_q;
  logic            sgn_q;
  logic [1:0]      size_q;
  logic [1:0]      idx;
  logic [AW-1:0]   addr_q;
  logic [31:0]     di_q;
  logic [31:0]     asm_q;
  logic [31:0]     asm_nxt;
  logic            at_last;
  logic            reject;

  // Index of the final byte for a given access size (Size 11 behaves as word).
  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Sign- or zero-extend the assembled load data to 32 bits.
  function automatic logic [31:0] extend(input logic [1:0] sz, input logic sg,
                                         input logic [31:0] w);
    case (sz)
      2'b00:   return {{24{sg & w[7]}}, w[7:0]};
      2'b01:   return {{16{sg & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

`ifdef MEM_LSU_ALIGN_CHECK_EN
  logic err_q;

  // Half needs an even address, word needs a multiple of four.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  assign reject = misaligned(Size, Addr[1:0]);
`else
  assign reject = 1'b0;
`endif

  assign at_last = (idx == last_idx(size_q));
  assign m_addr  = addr_q + AW'(idx);
  assign m_wdata = di_q[{idx, 3'b000} +: 8];

  // Assembly word with the incoming read byte merged at the current index.
  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{idx, 3'b000} +: 8] = m_rdata;
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and memory/pipeline handshake outputs.
  always_comb begin
    state_nxt = state;
    m_req     = 1'b0;
    m_we      = 1'b0;
    Busy      = (state != IDLE);
    Done      = 1'b0;
    Err       = 1'b0;
    case (state)
      IDLE: begin
        if (Req) state_nxt = reject ? DONE : ISSUE;
      end
      ISSUE: begin
        m_req = 1'b1;
        m_we  = wr_q;
        if (m_ready) begin
          if (!wr_q)        state_nxt = WAIT_R;
          else if (at_last) state_nxt = DONE;
        end
      end
      WAIT_R: begin
        if (m_rvalid) state_nxt = at_last ? DONE : ISSUE;
      end
      DONE: begin
        Done      = 1'b1;
`ifdef MEM_LSU_ALIGN_CHECK_EN
        Err       = err_q;
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, byte index and load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= 1'b0;
      sgn_q  <= 1'b0;
      size_q <= 2'b00;
      addr_q <= '0;
      di_q   <= '0;
      idx    <= 2'd0;
      Do     <= '0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Req) begin
            wr_q   <= MemWr;
            sgn_q  <= Signed;
            size_q <= Size;
            addr_q <= Addr;
            di_q   <= Di;
            idx    <= 2'd0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
            err_q  <= reject;
`endif
          end
        end
        ISSUE: begin
          if (m_ready && wr_q && !at_last) idx <= idx + 2'd1;
        end
        WAIT_R: begin
          if (m_rvalid) begin
            if (at_last) Do  <= extend(size_q, sgn_q, asm_nxt);
            else         idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Load assembly register; cleared on acceptance, filled byte by byte.
  always_ff @(posedge clk) begin
    if (state == IDLE && Req)          asm_q <= '0;
    else if (state == WAIT_R && m_rvalid) asm_q <= asm_nxt;
  end

endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
// tb_mem_lsu: randomized self-checking bench for mem_lsu with a byte memory
// responder (programmable ready stalls, rvalid delay, spurious rvalid pulses).
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Req, MemWr, Signed;
  logic [1:0]  Size;
  logic [31:0] Addr, Di, Do;
  logic        Busy, Done, Err;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_lsu #(.AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .MemWr(MemWr), .Size(Size),
    .Signed(Signed), .Addr(Addr), .Di(Di), .Do(Do), .Busy(Busy),
    .Done(Done), .Err(Err), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata)
  );

  int          nvec = 0;
  int          nerr = 0;
  bit [31:0]   exp_do;

  bit [7:0]    mem [bit [31:0]];
  int          ready_stall = 0;
  int          rv_delay    = 0;
  bit          spur_en     = 0;
  int          viol        = 0;
  bit [31:0]   hs_addr[$];
  bit          hs_we[$];
  bit [7:0]    hs_data[$];

  function automatic bit [7:0] rd_byte(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Byte memory: one request per handshake, read data after rv_delay cycles.
  initial begin : responder
    int        stall_cnt;
    bit        pend;
    int        pend_cnt;
    bit [7:0]  pend_data;
    stall_cnt = 0; pend = 0; pend_cnt = 0; pend_data = 0;
    m_ready = 0; m_rvalid = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rdata  = 8'($urandom);
      if (!rst_n) begin
        pend = 0; stall_cnt = 0; m_ready = 1'b0;
      end else begin
        if (pend) begin
          if (m_req) viol++;
          if (pend_cnt == 0) begin
            m_rvalid = 1'b1; m_rdata = pend_data; pend = 0;
          end else pend_cnt--;
        end
        if (m_req) begin
          if (spur_en && !m_rvalid) m_rvalid = 1'b1;
          if (stall_cnt < ready_stall) begin
            m_ready = 1'b0; stall_cnt++;
          end else begin
            m_ready = 1'b1; stall_cnt = 0;
            hs_addr.push_back(m_addr); hs_we.push_back(m_we); hs_data.push_back(m_wdata);
            if (m_we) mem[m_addr] = m_wdata;
            else begin pend = 1; pend_cnt = rv_delay; pend_data = rd_byte(m_addr); end
          end
        end else begin
          m_ready = 1'($urandom); stall_cnt = 0;
        end
      end
    end
  end

  // Call at a negedge with the DUT idle; returns at the negedge after Done.
  task automatic run_access(input bit wr, input bit [1:0] sz, input bit sg,
                            input bit [31:0] a, input bit [31:0] d,
                            input int rs, input int rd, input bit hold,
                            input bit spur, input string nm);
    int        n, exp_lat, cyc, busy_cnt, exp_hs;
    bit        mis, exp_err, done_seen, err_early;
    bit [31:0] val;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    exp_err = mis;
`else
    exp_err = 1'b0;
`endif
    val = 0;
    for (int i = 0; i < n; i++) val |= 32'(rd_byte(a + 32'(i))) << (8 * i);
    if (!wr && !exp_err) begin
      if (n == 1)      val = (sg && val[7])  ? (val | 32'hFFFF_FF00) : val;
      else if (n == 2) val = (sg && val[15]) ? (val | 32'hFFFF_0000) : val;
      exp_do = val;
    end
    exp_lat = exp_err ? 1 : wr ? n * (1 + rs) + 1 : n * (2 + rs + rd) + 1;
    exp_hs  = exp_err ? 0 : n;
    ready_stall = rs; rv_delay = rd; spur_en = spur;
    hs_addr.delete(); hs_we.delete(); hs_data.delete(); viol = 0;
    Req = 1'b1; MemWr = wr; Size = sz; Signed = sg; Addr = a; Di = d;
    @(posedge clk); #1;
    if (!hold) begin
      Req = 1'($urandom); MemWr = 1'($urandom); Size = 2'($urandom);
      Signed = 1'($urandom); Addr = $urandom; Di = $urandom;
    end
    cyc = 0; busy_cnt = 0; done_seen = 0; err_early = 0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (Busy) busy_cnt++;
      if (Done) done_seen = 1;
      else if (Err) err_early = 1;
      if (!hold) Req = 1'($urandom);
    end
    nvec++; if (done_seen !== 1'b1) begin nerr++; $display("FAIL %s done_timeout: no Done within %0d cycles", nm, cyc); end
    nvec++; if (cyc !== exp_lat) begin nerr++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc, exp_lat); end
    nvec++; if (busy_cnt !== exp_lat) begin nerr++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy_cnt, exp_lat); end
    nvec++; if (Err !== exp_err || err_early) begin nerr++; $display("FAIL %s err: got %b (early %b) expected %b", nm, Err, err_early, exp_err); end
    nvec++; if (Do !== exp_do) begin nerr++; $display("FAIL %s do_at_done: got %h expected %h", nm, Do, exp_do); end
    nvec++; if (hs_addr.size() !== exp_hs) begin nerr++; $display("FAIL %s handshakes: got %0d expected %0d", nm, hs_addr.size(), exp_hs); end
    nvec++; if (viol !== 0) begin nerr++; $display("FAIL %s req_in_wait: got %0d expected 0", nm, viol); end
    if (hs_addr.size() == exp_hs) begin
      for (int k = 0; k < exp_hs; k++) begin
        nvec++;
        if (hs_addr[k] !== a + 32'(k) || hs_we[k] !== wr || (wr && hs_data[k] !== d[8*k +: 8])) begin
          nerr++;
          $display("FAIL %s byte%0d: got addr %h we %b data %h expected addr %h we %b data %h",
                   nm, k, hs_addr[k], hs_we[k], hs_data[k], a + 32'(k), wr, d[8*k +: 8]);
        end
      end
    end
    @(negedge clk);
    Req = hold;
    nvec++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || Do !== exp_do) begin
      nerr++;
      $display("FAIL %s idle_after: got busy %b done %b err %b do %h expected 0 0 0 %h",
               nm, Busy, Done, Err, Do, exp_do);
    end
    spur_en = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; Req = 0; MemWr = 0; Size = 0; Signed = 0; Addr = 0; Di = 0;
    exp_do = 0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({Busy, Done, Err, m_req, m_we} !== 5'b0 || Do !== 32'h0 || m_addr !== 32'h0 || m_wdata !== 8'h0) begin
      nerr++;
      $display("FAIL reset_state: got busy %b done %b err %b req %b we %b do %h addr %h wdata %h expected all 0",
               Busy, Done, Err, m_req, m_we, Do, m_addr, m_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    run_access(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, "store_word");
  endtask

  task automatic test_load_byte;
    run_access(0, 2'b00, 1, 32'h13, 32'h0, 0, 0, 0, 0, "load_byte_s");
    nvec++; if (Do !== 32'hFFFF_FFDE) begin nerr++; $display("FAIL load_byte_s_value: got %h expected ffffffde", Do); end
    run_access(0, 2'b00, 0, 32'h13, 32'h0, 0, 0, 0, 0, "load_byte_u");
    nvec++; if (Do !== 32'h0000_00DE) begin nerr++; $display("FAIL load_byte_u_value: got %h expected 000000de", Do); end
  endtask

  task automatic test_load_half_stall;
    run_access(0, 2'b01, 1, 32'h12, 32'h0, 2, 3, 0, 0, "load_half_stall");
    nvec++; if (Do !== 32'hFFFF_DEAD) begin nerr++; $display("FAIL load_half_value: got %h expected ffffdead", Do); end
  endtask

  task automatic test_wrap;
    run_access(0, 2'b10, 0, 32'hFFFF_FFFE, 32'h0, 0, 0, 0, 0, "word_wrap_load");
    run_access(1, 2'b11, 0, 32'hFFFF_FFFF, 32'hA1B2_C3D4, 1, 0, 0, 0, "word_wrap_store");
  endtask

  task automatic test_reset_mid;
    ready_stall = 0; rv_delay = 0; spur_en = 0;
    hs_addr.delete(); hs_we.delete(); hs_data.delete();
    Req = 1; MemWr = 1; Size = 2'b10; Signed = 0; Addr = 32'h40; Di = 32'h1122_3344;
    @(posedge clk); #1; Req = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    exp_do = 0;
    nvec++;
    if (m_req !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || m_we !== 1'b0 || Do !== 32'h0) begin
      nerr++;
      $display("FAIL reset_mid_outputs: got req %b busy %b done %b we %b do %h expected 0 0 0 0 0",
               m_req, Busy, Done, m_we, Do);
    end
    nvec++;
    if (hs_addr.size() !== 2) begin nerr++; $display("FAIL reset_mid_bytes: got %0d expected 2", hs_addr.size()); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin nerr++; $display("FAIL reset_mid_release: got busy %b done %b expected 0 0", Busy, Done); end
    run_access(0, 2'b00, 0, 32'h13, 32'h0, 0, 0, 0, 0, "after_reset_load");
  endtask

  task automatic test_back_to_back;
    run_access(1, 2'b01, 0, 32'h20, 32'h0000_8F7E, 0, 0, 1, 0, "held_store");
    run_access(0, 2'b01, 1, 32'h20, 32'h0, 1, 1, 1, 1, "held_load_spur");
    run_access(0, 2'b00, 1, 32'h21, 32'h0, 0, 2, 0, 1, "b2b_byte_spur");
  endtask

  task automatic test_random;
    bit [31:0] a;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(7, 0) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(3, 0));
      else a = 32'($urandom_range(63, 0));
      run_access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                 $urandom_range(2, 0), $urandom_range(2, 0),
                 (t < 39) ? 1'($urandom) : 1'b0, 1'($urandom), "random");
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit between the pipeline MEM stage and the byte-wide data memory. It accepts one load or store request at a time from the pipeline and serialises it into 1, 2 or 4 little-endian byte transactions on a request/ready/rvalid memory port. Loads are reassembled and sign- or zero-extended. The pipeline is stalled via `Busy` until `Done`.

## Interface
- `AW`, default 32: address width, for both the pipeline address and the memory address.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `Req`  in  1: access request; sampled only in IDLE.
- `MemWr`  in  1: 1 = store, 0 = load.
- `Size`  in  2: access size. 00 = byte, 01 = half, 10 = word, 11 = word.
- `Signed`  in  1: load extension. 1 = sign-extend, 0 = zero-extend.
- `Addr`  in  AW: byte address of the lowest byte.
- `Di`  in  32: store data, taken from the low bytes.
- `Do`  out  32: load result.
- `Busy`  out  1: high while state ≠ IDLE.
- `Done`  out  1: one-cycle completion pulse.
- `Err`  out  1: one-cycle misalignment pulse (see Configuration).
- `m_req`  out  1: memory byte request.
- `m_we`  out  1: memory write enable.
- `m_addr`  out  AW: memory byte address.
- `m_wdata`  out  8: memory write byte.
- `m_ready`  in  1: memory accepts the request this cycle.
- `m_rvalid`  in  1: read byte valid.
- `m_rdata`  in  8: read byte.

## Operation
- States: IDLE, ISSUE, WAIT_R, DONE. Byte index `idx` is 2 bits.
- `last` = 0 for byte, 1 for half, 3 for word or Size 11.
- IDLE
  - On `Req`: latch MemWr, Size, Signed, Addr, Di; clear idx and the assembly register; go to ISSUE.
- ISSUE
  - `m_req` = 1, `m_we` = latched MemWr.
  - `m_addr` = latched Addr + idx, computed modulo 2^AW (wraps past all-ones).
  - `m_wdata` = Di byte idx.
  - On `m_req && m_ready`:
    - Store: if idx == last go to DONE, else idx+1 and stay in ISSUE.
    - Load: go to WAIT_R.
- WAIT_R
  - `m_req` = 0.
  - On `m_rvalid`: write `m_rdata` into assembly byte idx.
  - Then if idx == last go to DONE, else idx+1 and go to ISSUE.
- DONE
  - `Done` = 1.
  - On a load, `Do` is loaded with the extended result:
    - byte: bit 7 replicated if Signed, else zeros.
    - half: bit 15 replicated if Signed, else zeros.
    - word: unchanged.
  - `Do` is unchanged on a store.
  - Next state is IDLE.
- `Do` holds its value until the next completed load.
- Ignored inputs:
  - `m_rvalid` outside WAIT_R.
  - `Req` outside IDLE.
  - Inputs that change after acceptance (only the latched copies are used).
- Only one memory transaction is outstanding at a time; `m_req` is never high in WAIT_R.

## Timing
- Reset asserted, asynchronously:
  - State goes to IDLE.
  - `Busy`, `Done`, `Err`, `m_req`, `m_we` = 0.
  - `Do`, `m_addr`, `m_wdata` = 0.
- Reset mid-operation aborts the access and drops `m_req` immediately; no `Done` is produced.
- `Busy` rises in the cycle after the `Req` edge and falls in the cycle after DONE. `Busy` stays high during DONE.
- Zero-wait memory means `m_ready` = 1 and `m_rvalid` one cycle after acceptance. Under zero-wait memory:
  - Store: N byte cycles, then DONE, so `Done` appears N+1 cycles after acceptance.
  - Load: 2N cycles, then DONE, so `Done` appears 2N+1 cycles after acceptance.
  - N = 1, 2 or 4.
- Each cycle with `m_ready` low extends the access by one cycle. Each cycle of `m_rvalid` delay does the same.
- Back-to-back: the earliest next acceptance is the cycle after DONE, i.e. the IDLE cycle.

## Configuration
- `MEM_LSU_ALIGN_CHECK_EN` defined:
  - In IDLE, a `Req` with a misaligned address is rejected: half with Addr[0] = 1, or word/Size 11 with Addr[1:0] ≠ 0.
  - State goes to DONE with `Err` = 1 and `Done` = 1 in the same cycle.
  - No `m_req` is issued and `Do` is unchanged.
- `MEM_LSU_ALIGN_CHECK_EN` undefined:
  - `Err` is tied to 0.
  - Misaligned accesses proceed byte-serially at Addr, Addr+1, … with address wrap.

## Test plan
- Store word Di = 0xDEADBEEF at 0x10, zero-wait memory:
  - Bytes EF, BE, AD, DE written to 0x10–0x13.
  - `Done` 5 cycles after acceptance.
  - `Busy` high for exactly 5 cycles.
- Load byte at 0x13 (holds 0xDE):
  - Signed = 1 gives `Do` = 0xFFFFFFDE.
  - Signed = 0 gives `Do` = 0x000000DE.
  - `Done` 3 cycles after acceptance.
- Load half at 0x12 with `m_ready` low for 2 cycles and `m_rvalid` delayed by 3 cycles:
  - `Do` = 0xFFFFDEAD.
  - Exactly 2 `m_req` handshakes, one outstanding at a time.
- Word load at 0xFFFFFFFE (AW = 32):
  - With the macro defined: `Err` and `Done` in the same cycle, no `m_req`, `Do` unchanged.
  - Without the macro: addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Assert `rst_n` low during the 3rd byte of a word store:
  - `m_req` = 0 immediately and `Busy` = 0.
  - After release, a new byte load completes normally.
- `Req` held high through DONE:
  - The second access starts only from IDLE.
  - Spurious `m_rvalid` pulses in ISSUE do not corrupt `Do`.
